// File: rtl/ic_pkg.sv
// Shared definitions for the codec write master: FSM states, access-size step
// constants and the bit positions of the address_inc one-hot field.
package ic_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } mw_state_e;

   localparam logic [2:0] STEP_WORD = 3'd4;
   localparam logic [2:0] STEP_HW   = 3'd2;
   localparam logic [2:0] STEP_BYTE = 3'd1;

   localparam int INC_WORD_BIT = 2;
   localparam int INC_HW_BIT   = 1;
   localparam int INC_BYTE_BIT = 0;

   // WORD wins over HW over BYTE; an all-zero field falls back to WORD.
   function automatic logic [2:0] decode_step(input logic [2:0] inc);
      if (inc[INC_WORD_BIT] || !(inc[INC_HW_BIT] || inc[INC_BYTE_BIT])) begin
         return STEP_WORD;
      end else if (inc[INC_HW_BIT]) begin
         return STEP_HW;
      end else begin
         return STEP_BYTE;
      end
   endfunction

endpackage

// File: rtl/ic_mw_lane_align.sv
// Places a FIFO word onto the Avalon byte lanes for the current access size
// and low address bits. Purely combinational.
module ic_mw_lane_align
   import ic_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        addr_lsb_i,
   input  logic [2:0]        step_i,
   output logic [DATA_W-1:0] writedata_o,
   output logic [3:0]        byteenable_o
);

   // Narrow accesses replicate the low part so the addressed lane carries it.
   always_comb begin
      writedata_o  = data_i;
      byteenable_o = 4'b1111;
      case (step_i)
         STEP_HW: begin
            writedata_o  = {(DATA_W/16){data_i[15:0]}};
            byteenable_o = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
         end
         STEP_BYTE: begin
            writedata_o  = {(DATA_W/8){data_i[7:0]}};
            byteenable_o = 4'b0001 << addr_lsb_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ic_master_write.sv
// Avalon-MM write master: drains the codec output FIFO to memory starting at a
// software-programmed address, then reports completion and bytes written.
module ic_master_write
   import ic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MW_start,
   input  logic [ADDR_W-1:0] dest_address,
   input  logic [2:0]        address_inc,
   input  logic              IC_global_enable,
   input  logic              enc_last,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq,
   output logic [ADDR_W-1:0] MM_address,
   output logic              MM_write,
   output logic [DATA_W-1:0] MM_writedata,
   output logic [3:0]        MM_byteenable,
   input  logic              MM_waitrequest,
   output logic              MW_done,
   output logic [31:0]       IC_ByteCount
);

   mw_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [2:0]        step_q, step_d;
   logic [31:0]       count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] lane_data;
   logic [3:0]        lane_be;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cur_addr_q <= '0;
         step_q     <= '0;
         count_q    <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         step_q     <= step_d;
         count_q    <= count_d;
         data_q     <= data_d;
      end
   end

   // An abort seen in WRITE only takes effect once the slave accepts the beat.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      step_d     = step_q;
      count_d    = count_q;
      data_d     = data_q;
      fifo_rdreq = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MW_start) begin
               cur_addr_d = dest_address;
               step_d     = decode_step(address_inc);
               count_d    = '0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!IC_global_enable) begin
               state_d = S_IDLE;
            end else if (!fifo_empty) begin
               fifo_rdreq = 1'b1;
               data_d     = fifo_q;
               state_d    = S_WRITE;
            end else if (enc_last) begin
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            if (!MM_waitrequest) begin
               cur_addr_d = cur_addr_q + ADDR_W'(step_q);
               count_d    = count_q + 32'(step_q);
               state_d    = IC_global_enable ? S_FETCH : S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   ic_mw_lane_align #(
      .DATA_W(DATA_W)
   ) u_lane_align (
      .data_i      (data_q),
      .addr_lsb_i  (cur_addr_q[1:0]),
      .step_i      (step_q),
      .writedata_o (lane_data),
      .byteenable_o(lane_be)
   );

   // Bus outputs are forced to zero whenever no write is being presented.
   assign MM_write      = (state_q == S_WRITE);
   assign MM_address    = MM_write ? {cur_addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign MM_writedata  = MM_write ? lane_data : '0;
   assign MM_byteenable = MM_write ? lane_be : 4'b0000;
   assign MW_done       = (state_q == S_DONE);
   assign IC_ByteCount  = count_q;

endmodule

// File: tb/tb_ic_master_write.sv
// Self-checking bench for ic_master_write: a queue-based FIFO and memory log
// are compared against an address/lane model computed from the access rules.
module tb_ic_master_write;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MW_start = 1'b0;
   logic [31:0] dest_address = '0;
   logic [2:0]  address_inc = '0;
   logic        IC_global_enable = 1'b1;
   logic        enc_last = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_q = '0;
   logic        fifo_rdreq;
   logic [31:0] MM_address;
   logic        MM_write;
   logic [31:0] MM_writedata;
   logic [3:0]  MM_byteenable;
   logic        MM_waitrequest = 1'b0;
   logic        MW_done;
   logic [31:0] IC_ByteCount;

   int nAsserts = 0;
   int nFails = 0;
   int cycleCnt = 0;
   int popCount = 0;
   int doneCount = 0;
   int doneCyc = 0;
   int startCyc = 0;
   int stallLeft = 0;
   bit randWait = 0;
   bit popReq = 0;
   bit stallPrev = 0;
   logic [31:0] heldAddr, heldData;
   logic [3:0]  heldBe;

   logic [31:0] fifoQ[$];
   logic [31:0] expData[$];
   logic [31:0] logAddr[$];
   logic [31:0] logData[$];
   logic [3:0]  logBe[$];

   ic_master_write #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .MW_start        (MW_start),
      .dest_address    (dest_address),
      .address_inc     (address_inc),
      .IC_global_enable(IC_global_enable),
      .enc_last        (enc_last),
      .fifo_empty      (fifo_empty),
      .fifo_q          (fifo_q),
      .fifo_rdreq      (fifo_rdreq),
      .MM_address      (MM_address),
      .MM_write        (MM_write),
      .MM_writedata    (MM_writedata),
      .MM_byteenable   (MM_byteenable),
      .MM_waitrequest  (MM_waitrequest),
      .MW_done         (MW_done),
      .IC_ByteCount    (IC_ByteCount)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void updateFifo();
      fifo_empty = (fifoQ.size() == 0);
      fifo_q     = (fifoQ.size() != 0) ? fifoQ[0] : 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [31:0] d);
      fifoQ.push_back(d);
      expData.push_back(d);
      updateFifo();
   endtask

   function automatic int unsigned modelStep(input logic [2:0] inc);
      if (inc == 3'd0 || inc >= 3'd4) return 4;
      if (inc >= 3'd2) return 2;
      return 1;
   endfunction

   // Show-ahead FIFO model: a pop requested during a cycle retires the head after the edge.
   always @(posedge clk) begin
      cycleCnt++;
      #1;
      if (popReq) begin
         popCount++;
         if (fifoQ.size() != 0) void'(fifoQ.pop_front());
      end
      updateFifo();
   end

   // Avalon slave stall generator.
   always @(posedge clk) begin
      #1;
      if (MM_write && stallLeft > 0) begin
         MM_waitrequest = 1'b1;
         stallLeft--;
      end else if (randWait) begin
         MM_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
         MM_waitrequest = 1'b0;
      end
   end

   // Mid-cycle bus monitor: logs accepted beats and checks stability under stall.
   always @(negedge clk) begin
      popReq = fifo_rdreq;
      if (MW_done) begin
         doneCount++;
         doneCyc = cycleCnt;
      end
      if (reset) begin
         stallPrev = 0;
      end else if (MM_write) begin
         if (stallPrev) begin
            checkOutput("stall_addr", MM_address, heldAddr);
            checkOutput("stall_data", MM_writedata, heldData);
            checkOutput("stall_be", {28'h0, MM_byteenable}, {28'h0, heldBe});
         end
         if (!MM_waitrequest) begin
            logAddr.push_back(MM_address);
            logData.push_back(MM_writedata);
            logBe.push_back(MM_byteenable);
            stallPrev = 0;
         end else begin
            stallPrev = 1;
            heldAddr  = MM_address;
            heldData  = MM_writedata;
            heldBe    = MM_byteenable;
         end
      end else begin
         if (stallPrev) checkOutput("stall_write_held", {31'h0, MM_write}, 32'h1);
         stallPrev = 0;
      end
   end

   task automatic clearLogs();
      logAddr.delete();
      logData.delete();
      logBe.delete();
      popCount = 0;
   endtask

   task automatic applyStimulus(input logic [31:0] dest, input logic [2:0] inc);
      MW_start     = 1'b1;
      dest_address = dest;
      address_inc  = inc;
      startCyc     = cycleCnt;
      tick();
      MW_start     = 1'b0;
      dest_address = $urandom;
      address_inc  = 3'($urandom);
   endtask

   task automatic runTransfer(input string tag, input logic [31:0] dest, input logic [2:0] inc,
                              input int stallFirst, input bit extraStart);
      int n;
      int d0;
      int unsigned step;
      logic [31:0] a, lane, eAddr, eData;
      logic [3:0]  eBe;
      n = expData.size();
      d0 = doneCount;
      clearLogs();
      stallLeft = stallFirst;
      enc_last = 1'b1;
      applyStimulus(dest, inc);
      if (extraStart) begin
         repeat (2) tick();
         MW_start = 1'b1;
         tick();
         MW_start = 1'b0;
      end
      for (int c = 0; c < 400 && doneCount == d0; c++) tick();
      repeat (3) tick();
      checkOutput($sformatf("%s_done_pulses", tag), 32'(doneCount - d0), 32'd1);
      step = modelStep(inc);
      checkOutput($sformatf("%s_bytecount", tag), IC_ByteCount, 32'(n * step));
      checkOutput($sformatf("%s_nwrites", tag), 32'(logAddr.size()), 32'(n));
      checkOutput($sformatf("%s_pops", tag), 32'(popCount), 32'(n));
      for (int i = 0; i < n && i < logAddr.size(); i++) begin
         a     = dest + 32'(i * step);
         lane  = a % 4;
         eAddr = a - lane;
         if (step == 4) begin
            eBe = 4'hF;
            eData = expData[i];
         end else if (step == 2) begin
            eBe = (lane >= 2) ? 4'hC : 4'h3;
            eData = (expData[i] % 32'h10000) * 32'h00010001;
         end else begin
            eBe = 4'(1 << lane);
            eData = (expData[i] % 32'h100) * 32'h01010101;
         end
         checkOutput($sformatf("%s_addr%0d", tag, i), logAddr[i], eAddr);
         checkOutput($sformatf("%s_be%0d", tag, i), {28'h0, logBe[i]}, {28'h0, eBe});
         checkOutput($sformatf("%s_data%0d", tag, i), logData[i], eData);
      end
      expData.delete();
      enc_last = 1'b0;
      tick();
   endtask

   initial begin
      int d0;
      int n;
      updateFifo();
      repeat (3) tick();
      checkOutput("rst_mm_write", {31'h0, MM_write}, 32'h0);
      checkOutput("rst_mm_address", MM_address, 32'h0);
      checkOutput("rst_mm_writedata", MM_writedata, 32'h0);
      checkOutput("rst_mm_be", {28'h0, MM_byteenable}, 32'h0);
      checkOutput("rst_rdreq", {31'h0, fifo_rdreq}, 32'h0);
      checkOutput("rst_done", {31'h0, MW_done}, 32'h0);
      checkOutput("rst_bytecount", IC_ByteCount, 32'h0);
      reset = 1'b0;
      repeat (2) tick();

      $display("[TB] word run");
      repeat (3) pushWord($urandom);
      runTransfer("word", 32'h1000, 3'b100, 0, 0);

      $display("[TB] byte run");
      pushWord(32'h000000AA);
      pushWord(32'h000000BB);
      pushWord(32'h000000CC);
      pushWord(32'h000000DD);
      runTransfer("byte", 32'h2001, 3'b001, 0, 0);

      $display("[TB] half-word run with stall and ignored restart");
      repeat (3) pushWord($urandom);
      runTransfer("hw", 32'h3000, 3'b010, 5, 1);

      $display("[TB] empty with last");
      runTransfer("empty", 32'h4000, 3'b100, 0, 0);
      checkOutput("empty_done_latency", 32'(doneCyc - startCyc), 32'd2);

      $display("[TB] zero code and wrap");
      repeat (2) pushWord($urandom);
      runTransfer("zero_inc", 32'h5002, 3'b000, 0, 0);
      repeat (3) pushWord($urandom);
      runTransfer("wrap", 32'hFFFF_FFFE, 3'b011, 0, 0);

      $display("[TB] abort in fetch");
      clearLogs();
      d0 = doneCount;
      enc_last = 1'b0;
      applyStimulus(32'h6000, 3'b100);
      repeat (3) tick();
      IC_global_enable = 1'b0;
      repeat (3) tick();
      IC_global_enable = 1'b1;
      fifoQ.push_back(32'h1234_5678);
      updateFifo();
      enc_last = 1'b1;
      repeat (6) tick();
      checkOutput("abort_fetch_done", 32'(doneCount - d0), 32'd0);
      checkOutput("abort_fetch_writes", 32'(logAddr.size()), 32'd0);
      checkOutput("abort_fetch_pops", 32'(popCount), 32'd0);
      fifoQ.delete();
      updateFifo();
      enc_last = 1'b0;
      tick();

      $display("[TB] abort in write under stall");
      clearLogs();
      d0 = doneCount;
      repeat (3) pushWord($urandom);
      stallLeft = 4;
      applyStimulus(32'h7000, 3'b100);
      for (int c = 0; c < 20 && !MM_write; c++) tick();
      IC_global_enable = 1'b0;
      repeat (10) tick();
      checkOutput("abort_write_nwrites", 32'(logAddr.size()), 32'd1);
      if (logAddr.size() > 0) begin
         checkOutput("abort_write_addr", logAddr[0], 32'h7000);
         checkOutput("abort_write_data", logData[0], expData[0]);
      end
      checkOutput("abort_write_pops", 32'(popCount), 32'd1);
      checkOutput("abort_write_bytecount", IC_ByteCount, 32'd4);
      checkOutput("abort_write_done", 32'(doneCount - d0), 32'd0);
      checkOutput("abort_write_idle", {31'h0, MM_write}, 32'h0);
      IC_global_enable = 1'b1;
      fifoQ.delete();
      expData.delete();
      updateFifo();
      tick();

      $display("[TB] reset during write");
      clearLogs();
      d0 = doneCount;
      repeat (3) pushWord($urandom);
      applyStimulus(32'h8000, 3'b100);
      for (int c = 0; c < 20 && logAddr.size() == 0; c++) tick();
      stallLeft = 50;
      for (int c = 0; c < 20 && !MM_write; c++) tick();
      tick();
      checkOutput("pre_reset_bytecount", IC_ByteCount, 32'd4);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("reset_async_write", {31'h0, MM_write}, 32'h0);
      checkOutput("reset_async_bytecount", IC_ByteCount, 32'h0);
      checkOutput("reset_async_done", {31'h0, MW_done}, 32'h0);
      stallLeft = 0;
      fifoQ.delete();
      expData.delete();
      updateFifo();
      tick();
      tick();
      reset = 1'b0;
      tick();
      checkOutput("reset_no_done", 32'(doneCount - d0), 32'd0);
      repeat (2) pushWord($urandom);
      runTransfer("post_reset", 32'h8100, 3'b100, 0, 0);

      $display("[TB] randomized runs");
      randWait = 1;
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) pushWord($urandom);
         runTransfer($sformatf("rand%0d", r), $urandom, 3'($urandom_range(0, 7)), 0, 0);
      end
      randWait = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
